// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM state encoding, frame magic, error codes.
// Imported by the interface, the loader and its bench.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      DONE,
      ERR
   } loader_state_t;

   localparam logic [7:0] LOADER_MAGIC = 8'hA5;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_LEN  = 2'd1;
   localparam logic [1:0] ERR_CSUM = 2'd2;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader bus bundle: byte stream in (rx_*) and imem write port (mem_*).
// master = loader side, slave = stream source / memory side.
interface imem_loader_if #(
   parameter int ADDR_W = 12
);

   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      input  rx_valid,
      input  rx_data,
      output rx_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   modport slave (
      output rx_valid,
      output rx_data,
      input  rx_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

endinterface

// File: rtl/imem_loader.sv
// Boot loader: frames A5/LEN/payload/CSUM, packs bytes LE into words, writes imem.
// Ports: clk, rst_n (sync, low), start, bus (rx stream + mem port), cpu_rst_n, busy, done, err, err_code.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MEM_BYTES = 4096,
   parameter int ADDR_W    = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   imem_loader_if.master bus,
   output logic          cpu_rst_n,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [1:0]    err_code
);

   // One extra bit so LEN == MEM_BYTES fits.
   localparam int CW = ADDR_W + 1;

   loader_state_t state_q, state_d;
   logic [1:0]    err_code_d;
   logic [7:0]    len_lo_q;
   logic [CW-1:0] len_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_inc;
   logic [7:0]    csum_q;
   logic [23:0]   shift_q;
   logic [15:0]   len_chk;
   logic          len_bad;
   logic          acc;

   assign bus.rx_ready = (state_q != DONE) && (state_q != ERR);
   assign acc          = bus.rx_valid && bus.rx_ready;

   // Length check uses the high byte arriving this cycle.
   assign len_chk = {bus.rx_data, len_lo_q};
   assign len_bad = (len_chk == 16'd0)
                 || (len_chk[1:0] != 2'b00)
                 || (int'(len_chk) > MEM_BYTES);

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d    = state_q;
      err_code_d = err_code;
      if (start) begin
         state_d    = IDLE;
         err_code_d = ERR_NONE;
      end else if (acc) begin
         unique case (state_q)
            IDLE: begin
               if (bus.rx_data == LOADER_MAGIC)
                  state_d = LEN0;
            end
            LEN0: state_d = LEN1;
            LEN1: begin
               if (len_bad) begin
                  state_d    = ERR;
                  err_code_d = ERR_LEN;
               end else begin
                  state_d = DATA;
               end
            end
            DATA: begin
               if (cnt_inc == len_q)
                  state_d = CSUM;
            end
            CSUM: begin
               if (bus.rx_data == csum_q) begin
                  state_d = DONE;
               end else begin
                  state_d    = ERR;
                  err_code_d = ERR_CSUM;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         err_code      <= ERR_NONE;
         done          <= 1'b0;
         err           <= 1'b0;
         cpu_rst_n     <= 1'b0;
         busy          <= 1'b0;
         len_lo_q      <= '0;
         len_q         <= '0;
         cnt_q         <= '0;
         csum_q        <= '0;
         shift_q       <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         state_q    <= state_d;
         err_code   <= err_code_d;
         done       <= (state_d == DONE);
         err        <= (state_d == ERR);
         cpu_rst_n  <= (state_d == DONE);
         busy       <= (state_d == LEN0) || (state_d == LEN1)
                    || (state_d == DATA) || (state_d == CSUM);
         bus.mem_we <= 1'b0;
         if (start) begin
            shift_q <= '0;
         end else if (acc) begin
            if (state_q == LEN0)
               len_lo_q <= bus.rx_data;
            if (state_q == LEN1) begin
               len_q  <= len_chk[CW-1:0];
               cnt_q  <= '0;
               csum_q <= '0;
            end
            if (state_q == DATA) begin
               cnt_q   <= cnt_inc;
               csum_q  <= csum_q + bus.rx_data;
               // Newest byte enters the top; after b2 this holds {b2,b1,b0}.
               shift_q <= {bus.rx_data, shift_q[23:8]};
               if (cnt_q[1:0] == 2'b11) begin
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= {cnt_q[ADDR_W-1:2], 2'b00};
                  bus.mem_wdata <= {bus.rx_data, shift_q};
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random frames against a frame-level model.
// Writes are captured on the falling edge and compared as (addr, data) lists.
module tb_imem_loader;
   import imem_loader_pkg::*;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       cpu_rst_n, busy, done, err;
   logic [1:0] err_code;

   int n_cmp = 0;
   int n_bad = 0;

   bq_t         frm;
   logic [43:0] got[$];
   logic [43:0] exp_w[$];
   logic [1:0]  exp_code;
   logic        exp_done;
   logic        exp_err;
   logic [31:0] w0;

   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(12)) bus ();

   imem_loader #(.MEM_BYTES(4096), .ADDR_W(12)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .bus(bus),
      .cpu_rst_n(cpu_rst_n),
      .busy(busy),
      .done(done),
      .err(err),
      .err_code(err_code)
   );

   always @(negedge clk)
      if (bus.mem_we === 1'b1)
         got.push_back({bus.mem_addr, bus.mem_wdata});

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Frame-level reference: scan for magic, decode LEN, slice words, sum payload.
   task automatic model(input bq_t s);
      int i;
      int len;
      int sum;
      exp_w.delete();
      exp_code = ERR_NONE;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      i = 0;
      while (i < s.size() && s[i] != 8'hA5) i++;
      if (i + 2 >= s.size()) return;
      len = int'(s[i+1]) + 256 * int'(s[i+2]);
      i += 3;
      if (len == 0 || len % 4 != 0 || len > 4096) begin
         exp_err  = 1'b1;
         exp_code = 2'd1;
         return;
      end
      sum = 0;
      for (int k = 0; k < len; k++) begin
         sum += int'(s[i+k]);
         if (k % 4 == 3)
            exp_w.push_back({12'(k - 3), s[i+k], s[i+k-1], s[i+k-2], s[i+k-3]});
      end
      if (s[i+len] == 8'(sum)) begin
         exp_done = 1'b1;
      end else begin
         exp_err  = 1'b1;
         exp_code = 2'd2;
      end
   endtask

   task automatic build(input int len, input bit bad, input bit inc);
      logic [7:0] b;
      int sum;
      frm.delete();
      frm.push_back(8'hA5);
      frm.push_back(8'(len));
      frm.push_back(8'(len >> 8));
      sum = 0;
      for (int k = 0; k < len; k++) begin
         b = inc ? 8'(k) : 8'($urandom);
         frm.push_back(b);
         sum += int'(b);
      end
      frm.push_back(bad ? 8'(sum + 1) : 8'(sum));
   endtask

   task automatic idle(input int n);
      bus.rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_range(input int lo, input int hi, input int gap);
      for (int i = lo; i < hi; i++) begin
         if (gap > 0) idle($urandom_range(0, gap));
         send_byte(frm[i]);
      end
   endtask

   task automatic pulse_start(input bit with_byte);
      start        = 1'b1;
      bus.rx_valid = with_byte;
      bus.rx_data  = 8'hA5;
      @(negedge clk);
      start        = 1'b0;
      bus.rx_valid = 1'b0;
   endtask

   task automatic check_result(input string tag);
      int n;
      chk({tag, ".nwr"}, got.size(), exp_w.size());
      n = (got.size() < exp_w.size()) ? got.size() : exp_w.size();
      for (int i = 0; i < n; i++)
         chk({tag, ".wr"}, got[i], exp_w[i]);
      chk({tag, ".done"}, done, exp_done);
      chk({tag, ".err"}, err, exp_err);
      chk({tag, ".code"}, err_code, exp_code);
      chk({tag, ".cpu"}, cpu_rst_n, exp_done);
      chk({tag, ".busy"}, busy, 1'b0);
      chk({tag, ".rdy"}, bus.rx_ready, !(exp_done || exp_err));
      got.delete();
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst.rdy", bus.rx_ready, 1);
      chk("rst.we", bus.mem_we, 0);
      chk("rst.addr", bus.mem_addr, 0);
      chk("rst.wdata", bus.mem_wdata, 0);
      chk("rst.cpu", cpu_rst_n, 0);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.err", err, 0);
      chk("rst.code", err_code, 0);

      // Reference frame, back-to-back bytes, cycle-exact checks.
      frm = '{8'hA5, 8'h08, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
              8'h13, 8'h01, 8'h30, 8'h00, 8'h27};
      model(frm);
      for (int i = 0; i < frm.size(); i++) begin
         send_byte(frm[i]);
         if (i == 0) chk("A.busy_on", busy, 1);
         if (i == 6 || i == 10) chk("A.we_on", bus.mem_we, 1);
         if (i == 7 || i == 11) chk("A.we_off", bus.mem_we, 0);
         if (i == 11) begin
            chk("A.done_lat", done, 1);
            chk("A.cpu_lat", cpu_rst_n, 1);
            chk("A.busy_off", busy, 0);
         end
      end
      idle(2);
      chk("A.w0", got[0], {12'h000, 32'h00500093});
      chk("A.w1", got[1], {12'h004, 32'h00300113});
      check_result("A");

      // Same frame, bad checksum, random rx_valid gaps.
      pulse_start(0);
      chk("S.done", done, 0);
      chk("S.cpu", cpu_rst_n, 0);
      chk("S.code", err_code, 0);
      frm[11] = 8'h28;
      model(frm);
      send_range(0, frm.size(), 3);
      idle(2);
      check_result("B");

      // Bad lengths.
      pulse_start(0);
      chk("S.err", err, 0);
      frm = '{8'hA5, 8'h06, 8'h00};
      model(frm);
      send_range(0, frm.size(), 0);
      chk("C1.err_lat", err, 1);
      idle(2);
      check_result("C1");
      pulse_start(0);
      frm = '{8'hA5, 8'h04, 8'h10};
      model(frm);
      send_range(0, frm.size(), 2);
      idle(2);
      check_result("C2");

      // Junk before a valid frame, random gaps.
      pulse_start(0);
      frm = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h08, 8'h00, 8'h93, 8'h00,
              8'h50, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00, 8'h27};
      model(frm);
      send_range(0, 3, 2);
      chk("D.busy", busy, 0);
      chk("D.rdy", bus.rx_ready, 1);
      send_range(3, frm.size(), 4);
      idle(2);
      check_result("D");

      // Full memory image.
      pulse_start(0);
      build(4096, 0, 1);
      model(frm);
      send_range(0, frm.size(), 0);
      idle(2);
      chk("E.nwr", got.size(), 1024);
      chk("E.last", got[got.size()-1][43:32], 12'hFFC);
      check_result("E");

      // Abort after 6 payload bytes; start coincides with a dropped magic byte.
      pulse_start(0);
      build(16, 0, 0);
      send_range(0, 9, 0);
      w0 = {frm[6], frm[5], frm[4], frm[3]};
      pulse_start(1);
      chk("F.busy", busy, 0);
      chk("F.rdy", bus.rx_ready, 1);
      chk("F.cpu", cpu_rst_n, 0);
      idle(2);
      chk("F.busy2", busy, 0);
      chk("F.nwr", got.size(), 1);
      chk("F.w0", got[0], {12'h000, w0});
      got.delete();
      build(4 * $urandom_range(2, 16), 0, 0);
      model(frm);
      send_range(0, frm.size(), 2);
      idle(2);
      check_result("F2");

      // Reset in the middle of DATA.
      pulse_start(0);
      build(8, 0, 0);
      send_range(0, 7, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("H.rdy", bus.rx_ready, 1);
      chk("H.we", bus.mem_we, 0);
      chk("H.addr", bus.mem_addr, 0);
      chk("H.wdata", bus.mem_wdata, 0);
      chk("H.cpu", cpu_rst_n, 0);
      chk("H.busy", busy, 0);
      chk("H.done", done, 0);
      chk("H.err", err, 0);
      chk("H.code", err_code, 0);
      rst_n = 1'b1;
      idle(1);
      got.delete();

      // Random frames, occasionally with a corrupted checksum.
      for (int r = 0; r < 4; r++) begin
         pulse_start(0);
         build(4 * $urandom_range(1, 32), $urandom_range(0, 3) == 0, 0);
         model(frm);
         send_range(0, frm.size(), 3);
         idle(2);
         check_result("R");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
